// File: rtl/dist_filter_if.sv
// dist_filter_if: raw topcalc distance samples in; averaged distance, BCD digits and stale flag out.
interface dist_filter_if #(
    parameter int DW = 6
);
    logic [DW-1:0] din;
    logic          din_valid;
    logic [2:0]    zero_in;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic [3:0]    bcd_tens;
    logic [3:0]    bcd_ones;
    logic          bcd_valid;
    logic          stale;
    modport master (
        output din, din_valid, zero_in,
        input  dout, dout_valid, bcd_tens, bcd_ones, bcd_valid, stale
    );
    modport slave (
        input  din, din_valid, zero_in,
        output dout, dout_valid, bcd_tens, bcd_ones, bcd_valid, stale
    );
endinterface

// File: rtl/dist_filter.sv
// dist_filter: rejects no-match samples, moving-averages the rest, flags stale data and converts to BCD.
// Optional DIST_MEDIAN3_EN inserts a 3-tap median ahead of the averager.
module dist_filter #(
    parameter int DW = 6,
    parameter int LOG2_N = 3,
    parameter int STALE_CYC = 1000000
) (
    input logic clk,
    input logic rst,
    dist_filter_if.slave bus
);
    localparam int N = 1 << LOG2_N;
    localparam int SUMW = DW + LOG2_N;
    localparam int SW = $clog2(STALE_CYC + 1);
    localparam int CW = $clog2(DW + 1);
    localparam logic [LOG2_N:0] FULL = (LOG2_N + 1)'(N);
    localparam logic [SW-1:0] SMAX = SW'(STALE_CYC);
    localparam logic [SW-1:0] SPRE = SW'(STALE_CYC - 1);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    logic acc, expire, wr;
    logic [DW-1:0] wv;
    logic [DW-1:0] sbuf_q [N];
    logic [LOG2_N-1:0] wp_q;
    logic [LOG2_N:0] fill_q;
    logic [SUMW-1:0] sum_q;
    logic [SW-1:0] scnt_q;
    logic stale_q, wr_q, dv_q;
    logic [DW-1:0] dout_q;
    assign acc = bus.din_valid && bus.zero_in == 3'b000;
    assign expire = !acc && scnt_q == SPRE;
`ifdef DIST_MEDIAN3_EN
    logic [DW-1:0] m0_q, m1_q, med_q;
    logic [1:0] mcnt_q;
    logic mv_q;
    function automatic logic [DW-1:0] med3(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [DW-1:0] c);
        logic [DW-1:0] lo, hi;
        lo = a < b ? a : b;
        hi = a < b ? b : a;
        return c > hi ? hi : (c < lo ? lo : c);
    endfunction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m0_q <= '0;
            m1_q <= '0;
            med_q <= '0;
            mcnt_q <= '0;
            mv_q <= 1'b0;
        end else if (expire) begin
            m0_q <= '0;
            m1_q <= '0;
            mcnt_q <= '0;
            mv_q <= 1'b0;
        end else begin
            mv_q <= acc && mcnt_q == 2'd2;
            if (acc) begin
                med_q <= med3(m1_q, m0_q, bus.din);
                m1_q <= m0_q;
                m0_q <= bus.din;
                if (mcnt_q != 2'd2) mcnt_q <= mcnt_q + 2'd1;
            end
        end
    end
    assign wr = mv_q;
    assign wv = med_q;
`else
    assign wr = acc;
    assign wv = bus.din;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) sbuf_q[i] <= '0;
            wp_q <= '0;
            fill_q <= '0;
            sum_q <= '0;
            scnt_q <= '0;
            stale_q <= 1'b0;
            wr_q <= 1'b0;
            dv_q <= 1'b0;
            dout_q <= '0;
        end else begin
            wr_q <= wr;
            dv_q <= wr_q && fill_q == FULL;
            if (wr_q && fill_q == FULL) dout_q <= DW'(sum_q >> LOG2_N);
            if (acc) begin
                scnt_q <= '0;
                stale_q <= 1'b0;
            end else if (scnt_q != SMAX) begin
                scnt_q <= scnt_q + SW'(1);
            end
            // expiry restarts the window; an accepted sample on the same edge suppresses it
            if (expire) begin
                stale_q <= 1'b1;
                for (int i = 0; i < N; i++) sbuf_q[i] <= '0;
                wp_q <= '0;
                fill_q <= '0;
                sum_q <= '0;
            end else if (wr) begin
                sbuf_q[wp_q] <= wv;
                sum_q <= sum_q + SUMW'(wv) - SUMW'(sbuf_q[wp_q]);
                wp_q <= wp_q + LOG2_N'(1);
                if (fill_q != FULL) fill_q <= fill_q + (LOG2_N + 1)'(1);
            end
        end
    end
    state_t st_q, st_d;
    logic [DW-1:0] sh_q, sh_d, lat_q, lat_d;
    logic [3:0] t_q, t_d, o_q, o_d, ta, oa, tens_q, tens_d, ones_q, ones_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic pend_q, pend_d, bv_q, bv_d;
    always_comb begin
        st_d = st_q;
        sh_d = sh_q;
        t_d = t_q;
        o_d = o_q;
        cnt_d = cnt_q;
        pend_d = pend_q;
        lat_d = lat_q;
        tens_d = tens_q;
        ones_d = ones_q;
        bv_d = 1'b0;
        ta = t_q >= 4'd5 ? t_q + 4'd3 : t_q;
        oa = o_q >= 4'd5 ? o_q + 4'd3 : o_q;
        if (dv_q && st_q != IDLE) begin
            pend_d = 1'b1;
            lat_d = dout_q;
        end
        case (st_q)
            IDLE: if (dv_q) begin
                st_d = SHIFT;
                sh_d = dout_q;
                t_d = '0;
                o_d = '0;
                cnt_d = CW'(DW);
            end
            SHIFT: begin
                {t_d, o_d, sh_d} = {ta, oa, sh_q} << 1;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) st_d = DONE;
            end
            default: begin
                tens_d = t_q;
                ones_d = o_q;
                bv_d = 1'b1;
                st_d = pend_d ? SHIFT : IDLE;
                if (pend_d) begin
                    sh_d = lat_d;
                    t_d = '0;
                    o_d = '0;
                    cnt_d = CW'(DW);
                    pend_d = 1'b0;
                end
            end
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q <= IDLE;
            sh_q <= '0;
            lat_q <= '0;
            t_q <= '0;
            o_q <= '0;
            cnt_q <= '0;
            pend_q <= 1'b0;
            tens_q <= '0;
            ones_q <= '0;
            bv_q <= 1'b0;
        end else begin
            st_q <= st_d;
            sh_q <= sh_d;
            lat_q <= lat_d;
            t_q <= t_d;
            o_q <= o_d;
            cnt_q <= cnt_d;
            pend_q <= pend_d;
            tens_q <= tens_d;
            ones_q <= ones_d;
            bv_q <= bv_d;
        end
    end
    assign bus.dout = dout_q;
    assign bus.dout_valid = dv_q;
    assign bus.bcd_tens = tens_q;
    assign bus.bcd_ones = ones_q;
    assign bus.bcd_valid = bv_q;
    assign bus.stale = stale_q;
endmodule
